// File: rtl/video_pkg.sv
// Shared timing defaults, derived totals and pixel types for the scan-out block.
package video_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int ADDR_W = 19;

  typedef logic [23:0] rgb_t;

  typedef enum logic {
    SW_IDLE,
    SW_PEND
  } swap_state_e;

endpackage

// File: rtl/video_scanout_if.sv
// Frame-buffer and display-side signals of the scan-out block.
interface video_scanout_if;

  logic [video_pkg::ADDR_W-1:0] rd_addr;
  logic                         rd_data;
  logic                         swap_req;
  logic                         swap;
  logic                         vblank;
  logic                         hsync;
  logic                         vsync;
  logic                         de;
  video_pkg::rgb_t              rgb;

  modport master (
    output rd_addr, swap, vblank, hsync, vsync, de, rgb,
    input  rd_data, swap_req
  );

  modport slave (
    input  rd_addr, swap, vblank, hsync, vsync, de, rgb,
    output rd_data, swap_req
  );

endinterface

// File: rtl/video_timing.sv
// Horizontal/vertical counters and undelayed sync, active-area and vblank flags.
module video_timing import video_pkg::*; #(
  parameter int  H_ACTIVE = H_ACTIVE_DEF,
  parameter int  H_FP     = H_FP_DEF,
  parameter int  H_SYNC   = H_SYNC_DEF,
  parameter int  H_BP     = H_BP_DEF,
  parameter int  V_ACTIVE = V_ACTIVE_DEF,
  parameter int  V_FP     = V_FP_DEF,
  parameter int  V_SYNC   = V_SYNC_DEF,
  parameter int  V_BP     = V_BP_DEF,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW       = $clog2(H_TOTAL + 1),
  localparam int VW       = $clog2(V_TOTAL + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          active,
  output logic          hs_pulse,
  output logic          vs_pulse,
  output logic          vblank
);

  logic h_last;
  logic v_last;

  assign h_last = (h_cnt == HW'(H_TOTAL - 1));
  assign v_last = (v_cnt == VW'(V_TOTAL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_last ? '0 : h_cnt + HW'(1);
      if (h_last) begin
        v_cnt <= v_last ? '0 : v_cnt + VW'(1);
      end
    end
  end

  // Sync pulses are kept active-high here; the top inverts them at the pins.
  assign active   = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
  assign hs_pulse = (h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_pulse = (v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));
  assign vblank   = (v_cnt >= VW'(V_ACTIVE));

endmodule

// File: rtl/video_scanout.sv
// Frame-buffer scan-out: linear read address, latency-matched sync/de/rgb, swap arbitration.
// state   | meaning
// SW_IDLE | no buffer swap requested
// SW_PEND | renderer finished a frame; swap at next vblank entry
module video_scanout import video_pkg::*; #(
  parameter int   H_ACTIVE   = H_ACTIVE_DEF,
  parameter int   H_FP       = H_FP_DEF,
  parameter int   H_SYNC     = H_SYNC_DEF,
  parameter int   H_BP       = H_BP_DEF,
  parameter int   V_ACTIVE   = V_ACTIVE_DEF,
  parameter int   V_FP       = V_FP_DEF,
  parameter int   V_SYNC     = V_SYNC_DEF,
  parameter int   V_BP       = V_BP_DEF,
  parameter int   RD_LATENCY = 1,
  parameter rgb_t FG         = 24'hFFFFFF,
  parameter rgb_t BG         = 24'h000000
) (
  input logic             clk,
  input logic             rst_n,
  video_scanout_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);

  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic              active, hs_pulse, vs_pulse, vblank_raw;
  logic              frame_end, at_entry;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        raw_sig, tap_sig;
  logic [2:0]        dly_q [RD_LATENCY:0];
  rgb_t              rgb_q;
  swap_state_e       state_q, state_d;
  logic              swap_d;

  video_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk      (clk),
    .rst_n    (rst_n),
    .h_cnt    (h_cnt),
    .v_cnt    (v_cnt),
    .active   (active),
    .hs_pulse (hs_pulse),
    .vs_pulse (vs_pulse),
    .vblank   (vblank_raw)
  );

  assign frame_end = (h_cnt == HW'(H_TOTAL - 1)) && (v_cnt == VW'(V_TOTAL - 1));
  assign at_entry  = (h_cnt == '0) && (v_cnt == VW'(V_ACTIVE));

  // Running pixel index replaces v*H_ACTIVE+h; it parks on blanking clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else if (frame_end) begin
      addr_q <= '0;
    end else if (active) begin
      addr_q <= addr_q + ADDR_W'(1);
    end
  end

  assign raw_sig = {hs_pulse, vs_pulse, active};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= RD_LATENCY; i++) dly_q[i] <= '0;
    end else begin
      dly_q[0] <= raw_sig;
      for (int i = 1; i <= RD_LATENCY; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  // rgb is built from the de that lines up with rd_data, then registered once more.
  generate
    if (RD_LATENCY == 0) begin : g_tap_raw
      assign tap_sig = raw_sig;
    end else begin : g_tap_dly
      assign tap_sig = dly_q[RD_LATENCY-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= tap_sig[0] ? (bus.rd_data ? FG : BG) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SW_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    swap_d  = 1'b0;
    case (state_q)
      SW_IDLE: begin
        if (at_entry && bus.swap_req) swap_d  = 1'b1;
        else if (bus.swap_req)        state_d = SW_PEND;
      end
      SW_PEND: begin
        if (at_entry) begin
          swap_d  = 1'b1;
          state_d = SW_IDLE;
        end
      end
      default: state_d = SW_IDLE;
    endcase
  end

  assign bus.rd_addr = addr_q;
  assign bus.swap    = swap_d;
  assign bus.vblank  = vblank_raw;
  assign bus.hsync   = ~dly_q[RD_LATENCY][2];
  assign bus.vsync   = ~dly_q[RD_LATENCY][1];
  assign bus.de      = dly_q[RD_LATENCY][0];
  assign bus.rgb     = rgb_q;

endmodule

// File: tb/tb_video_scanout.sv
// Self-checking bench for video_scanout using a reduced 15x10 raster.
module tb_video_scanout;
  import video_pkg::*;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 6, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam rgb_t FGC = 24'h12AB34;
  localparam rgb_t BGC = 24'h00FF00;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  video_scanout_if bus();

  video_scanout #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .RD_LATENCY (1), .FG (FGC), .BG (BGC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // frame buffer holding rd_data = address LSB, one clock read latency
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.rd_data <= 1'b0;
    else        bus.rd_data <= bus.rd_addr[0];
  end

  int total = 0;
  int bad = 0;
  int k = 0;
  int swap_cnt = 0;
  logic stats_en = 1'b0;
  int de_hi = 0, hs_lo = 0, vs_lo = 0, hs_fall = 0, vs_fall = 0;
  logic hs_prev = 1'b1, vs_prev = 1'b1;

  typedef struct {
    int          cyc;
    logic        hs;
    logic        vs;
    logic        de;
    logic        vb;
    logic [18:0] addr;
    rgb_t        rgb;
  } vec_t;

  vec_t vecs[$];

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s k=%0d actual=%0h required=%0h", name, k, act, exp);
    end
  endtask

  function automatic void raw_at(input int j, output logic act, output logic hsl,
                                 output logic vsl, output logic vb, output logic [18:0] addr);
    int h, v;
    h    = j % HT;
    v    = (j / HT) % VT;
    act  = (h < HA) && (v < VA);
    hsl  = (h >= HA + HF) && (h < HA + HF + HS);
    vsl  = (v >= VA + VF) && (v < VA + VF + VS);
    vb   = (v >= VA);
    addr = (v < VA) ? 19'(v * HA + ((h < HA) ? h : HA)) : 19'(HA * VA);
  endfunction

  task automatic check_model();
    logic a0, h0, v0, b0, a2, h2, v2, b2;
    logic [18:0] ad0, ad2;
    logic e_hs, e_vs, e_de;
    rgb_t e_rgb;
    raw_at(k, a0, h0, v0, b0, ad0);
    if (k >= 2) begin
      raw_at(k - 2, a2, h2, v2, b2, ad2);
      e_hs  = ~h2;
      e_vs  = ~v2;
      e_de  = a2;
      e_rgb = a2 ? (ad2[0] ? FGC : BGC) : 24'h0;
    end else begin
      e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_rgb = 24'h0;
    end
    check1("rd_addr", 32'(bus.rd_addr), 32'(ad0));
    check1("vblank", 32'(bus.vblank), 32'(b0));
    check1("hsync", 32'(bus.hsync), 32'(e_hs));
    check1("vsync", 32'(bus.vsync), 32'(e_vs));
    check1("de", 32'(bus.de), 32'(e_de));
    check1("rgb", 32'(bus.rgb), 32'(e_rgb));
    if (bus.swap === 1'b1) begin
      swap_cnt++;
      check1("swap_position", {16'(k % HT), 16'((k / HT) % VT)}, {16'd0, 16'(VA)});
    end
    if (stats_en && k >= 2 && k < 2 + 2 * FR) begin
      if (bus.de) de_hi++;
      if (!bus.hsync) hs_lo++;
      if (!bus.vsync) vs_lo++;
      if (hs_prev && !bus.hsync) hs_fall++;
      if (vs_prev && !bus.vsync) vs_fall++;
      hs_prev = bus.hsync;
      vs_prev = bus.vsync;
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    k++;
    check_model();
  endtask

  task automatic pulse_req();
    bus.swap_req = 1'b1;
    @(posedge clk);
    #1;
    bus.swap_req = 1'b0;
    @(negedge clk);
    #1;
    k++;
    check_model();
  endtask

  task automatic goto_pos(input int h, input int v);
    logic found;
    found = 1'b0;
    for (int n = 0; n < 3 * FR && !found; n++) begin
      if ((k % HT) == h && ((k / HT) % VT) == v) found = 1'b1;
      else step();
    end
    if (!found) begin
      bad++;
      total++;
      $display("FAIL goto_timeout k=%0d actual=(%0d,%0d) required=(%0d,%0d)",
               k, k % HT, (k / HT) % VT, h, v);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check1({tag, "_rd_addr"}, 32'(bus.rd_addr), 32'd0);
    check1({tag, "_hsync"}, 32'(bus.hsync), 32'd1);
    check1({tag, "_vsync"}, 32'(bus.vsync), 32'd1);
    check1({tag, "_de"}, 32'(bus.de), 32'd0);
    check1({tag, "_rgb"}, 32'(bus.rgb), 32'd0);
    check1({tag, "_swap"}, 32'(bus.swap), 32'd0);
    check1({tag, "_vblank"}, 32'(bus.vblank), 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    k = 0;
    check_model();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog k=%0d actual=running required=finished", k);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    //           cyc  hs    vs    de    vb    addr    rgb
    vecs.push_back('{0,   1'b1, 1'b1, 1'b0, 1'b0, 19'd0,  24'h0});
    vecs.push_back('{1,   1'b1, 1'b1, 1'b0, 1'b0, 19'd1,  24'h0});
    vecs.push_back('{2,   1'b1, 1'b1, 1'b1, 1'b0, 19'd2,  BGC});
    vecs.push_back('{3,   1'b1, 1'b1, 1'b1, 1'b0, 19'd3,  FGC});
    vecs.push_back('{8,   1'b1, 1'b1, 1'b1, 1'b0, 19'd8,  BGC});
    vecs.push_back('{9,   1'b1, 1'b1, 1'b1, 1'b0, 19'd8,  FGC});
    vecs.push_back('{10,  1'b1, 1'b1, 1'b0, 1'b0, 19'd8,  24'h0});
    vecs.push_back('{12,  1'b0, 1'b1, 1'b0, 1'b0, 19'd8,  24'h0});
    vecs.push_back('{14,  1'b0, 1'b1, 1'b0, 1'b0, 19'd8,  24'h0});
    vecs.push_back('{15,  1'b1, 1'b1, 1'b0, 1'b0, 19'd8,  24'h0});
    vecs.push_back('{17,  1'b1, 1'b1, 1'b1, 1'b0, 19'd10, BGC});
    vecs.push_back('{82,  1'b1, 1'b1, 1'b1, 1'b0, 19'd47, FGC});
    vecs.push_back('{84,  1'b1, 1'b1, 1'b1, 1'b0, 19'd48, FGC});
    vecs.push_back('{90,  1'b1, 1'b1, 1'b0, 1'b1, 19'd48, 24'h0});
    vecs.push_back('{107, 1'b1, 1'b0, 1'b0, 1'b1, 19'd48, 24'h0});
    vecs.push_back('{137, 1'b1, 1'b1, 1'b0, 1'b1, 19'd48, 24'h0});
    vecs.push_back('{149, 1'b0, 1'b1, 1'b0, 1'b1, 19'd48, 24'h0});
    vecs.push_back('{150, 1'b1, 1'b1, 1'b0, 1'b0, 19'd0,  24'h0});
    vecs.push_back('{152, 1'b1, 1'b1, 1'b1, 1'b0, 19'd2,  BGC});
    vecs.push_back('{153, 1'b1, 1'b1, 1'b1, 1'b0, 19'd3,  FGC});

    bus.swap_req = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_values("por");

    stats_en = 1'b1;
    release_reset();
    foreach (vecs[i]) begin
      while (k < vecs[i].cyc) step();
      check1($sformatf("vec%0d_hsync", i), 32'(bus.hsync), 32'(vecs[i].hs));
      check1($sformatf("vec%0d_vsync", i), 32'(bus.vsync), 32'(vecs[i].vs));
      check1($sformatf("vec%0d_de", i), 32'(bus.de), 32'(vecs[i].de));
      check1($sformatf("vec%0d_vblank", i), 32'(bus.vblank), 32'(vecs[i].vb));
      check1($sformatf("vec%0d_rd_addr", i), 32'(bus.rd_addr), 32'(vecs[i].addr));
      check1($sformatf("vec%0d_rgb", i), 32'(bus.rgb), 32'(vecs[i].rgb));
    end
    while (k < 2 + 2 * FR) step();
    stats_en = 1'b0;
    check1("de_clocks_2frames", 32'(de_hi), 32'(2 * HA * VA));
    check1("hsync_low_2frames", 32'(hs_lo), 32'(2 * VT * HS));
    check1("vsync_low_2frames", 32'(vs_lo), 32'(2 * VS * HT));
    check1("hsync_periods", 32'(hs_fall), 32'(2 * VT));
    check1("vsync_periods", 32'(vs_fall), 32'd2);
    check1("no_swap_freerun", 32'(swap_cnt), 32'd0);

    // single request mid-frame
    swap_cnt = 0;
    goto_pos(3, 2);
    pulse_req();
    goto_pos(5, VA);
    check1("swap_single", 32'(swap_cnt), 32'd1);
    step();
    goto_pos(5, VA);
    check1("swap_single_no_repeat", 32'(swap_cnt), 32'd1);

    // three requests within one frame collapse to one swap
    swap_cnt = 0;
    goto_pos(2, 1);
    pulse_req();
    goto_pos(5, 3);
    pulse_req();
    goto_pos(4, 5);
    pulse_req();
    goto_pos(5, VA);
    check1("swap_absorbed", 32'(swap_cnt), 32'd1);
    step();
    goto_pos(5, VA);
    check1("swap_absorbed_next", 32'(swap_cnt), 32'd1);

    // request on the vblank-entry clock fires immediately
    swap_cnt = 0;
    goto_pos(2, 2);
    goto_pos(0, VA);
    bus.swap_req = 1'b1;
    #1;
    check1("swap_on_entry", 32'(bus.swap), 32'd1);
    if (bus.swap === 1'b1) swap_cnt++;
    @(posedge clk);
    #1;
    bus.swap_req = 1'b0;
    @(negedge clk);
    #1;
    k++;
    check_model();
    step();
    goto_pos(5, VA);
    check1("swap_on_entry_once", 32'(swap_cnt), 32'd1);

    // request just after vblank entry waits a whole frame
    swap_cnt = 0;
    goto_pos(1, VA);
    pulse_req();
    goto_pos(HT - 1, VT - 1);
    check1("late_req_waits", 32'(swap_cnt), 32'd0);
    goto_pos(1, VA);
    check1("late_req_fires", 32'(swap_cnt), 32'd1);

    // reset mid-frame with a swap pending
    swap_cnt = 0;
    goto_pos(3, 2);
    pulse_req();
    goto_pos(0, 4);
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    repeat (2) @(negedge clk);
    #1;
    check_reset_values("midrst_hold");
    release_reset();
    goto_pos(5, VA);
    step();
    goto_pos(5, VA);
    check1("reset_drops_pending", 32'(swap_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
